// File: rtl/display_mux_scan_if.sv
// rtl/display_mux_scan_if.sv - load/display bundle for the multiplexed 7-segment scanner
interface display_mux_scan_if #(
  parameter int N_DIGITS = 4
);
  logic [4*N_DIGITS-1:0] data_in;
  logic [N_DIGITS-1:0]   dp_in;
  logic                  load;
  logic                  blank_lz_en;
  logic [6:0]            seg_out;
  logic                  dp_out;
  logic [N_DIGITS-1:0]   an_out;
  logic                  frame_tick;
  logic                  update_pending;

  modport master (
    output data_in, dp_in, load, blank_lz_en,
    input  seg_out, dp_out, an_out, frame_tick, update_pending
  );

  modport slave (
    input  data_in, dp_in, load, blank_lz_en,
    output seg_out, dp_out, an_out, frame_tick, update_pending
  );
endinterface

// File: rtl/display_mux_scan.sv
// rtl/display_mux_scan.sv - time-multiplexed N-digit 7-segment driver with frame-aligned updates
module display_mux_scan #(
  parameter int N_DIGITS       = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input logic               clk,
  input logic               rst,
  display_mux_scan_if.slave bus
);
  localparam int DIV_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_DIGITS - 1);
  localparam logic [6:0]          SEG_INV  = {7{SEG_ACTIVE_LOW != 0}};
  localparam logic                DP_INV   = (SEG_ACTIVE_LOW != 0);
  localparam logic [N_DIGITS-1:0] AN_INV   = {N_DIGITS{AN_ACTIVE_LOW != 0}};

  logic [DIV_W-1:0]      div_cnt;
  logic [IDX_W-1:0]      idx;
  logic [4*N_DIGITS-1:0] pend_data;
  logic [N_DIGITS-1:0]   pend_dp;
  logic                  upd_pending;
  logic [4*N_DIGITS-1:0] shadow_data;
  logic [N_DIGITS-1:0]   shadow_dp;

  logic [6:0]            seg_q;
  logic                  dp_q;
  logic [N_DIGITS-1:0]   an_q;
  logic                  tick_q;

  logic                  digit_end;
  logic                  boundary;
  logic [3:0]            active_nib;
  logic                  active_dp;
  logic                  active_blank;
  logic [N_DIGITS-1:0]   an_onehot;
  logic                  zero_run;
  logic [6:0]            seg_next;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'h0: seg_decode = 7'h3F;
      4'h1: seg_decode = 7'h06;
      4'h2: seg_decode = 7'h5B;
      4'h3: seg_decode = 7'h4F;
      4'h4: seg_decode = 7'h66;
      4'h5: seg_decode = 7'h6D;
      4'h6: seg_decode = 7'h7D;
      4'h7: seg_decode = 7'h07;
      4'h8: seg_decode = 7'h7F;
      4'h9: seg_decode = 7'h6F;
      4'hA: seg_decode = 7'h77;
      4'hB: seg_decode = 7'h7C;
      4'hC: seg_decode = 7'h39;
      4'hD: seg_decode = 7'h5E;
      4'hE: seg_decode = 7'h79;
      default: seg_decode = 7'h71;
    endcase
  endfunction

  assign digit_end = (div_cnt == DIV_LAST);
  assign boundary  = digit_end && (idx == IDX_LAST);

  // Walk digits from the most significant down so zero_run tells whether
  // every nibble at or above k is zero, which is the blanking condition.
  always_comb begin
    active_nib   = 4'h0;
    active_dp    = 1'b0;
    active_blank = 1'b0;
    an_onehot    = '0;
    zero_run     = 1'b1;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run && (shadow_data[4*k +: 4] == 4'h0);
      if (idx == IDX_W'(k)) begin
        active_nib   = shadow_data[4*k +: 4];
        active_dp    = shadow_dp[k];
        active_blank = bus.blank_lz_en && (k != 0) && zero_run;
        an_onehot[k] = 1'b1;
      end
    end
  end

  assign seg_next = active_blank ? 7'h00 : seg_decode(active_nib);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt     <= '0;
      idx         <= '0;
      pend_data   <= '0;
      pend_dp     <= '0;
      upd_pending <= 1'b0;
      shadow_data <= '0;
      shadow_dp   <= '0;
      seg_q       <= SEG_INV;
      dp_q        <= DP_INV;
      an_q        <= AN_INV;
      tick_q      <= 1'b0;
    end else begin
      div_cnt <= digit_end ? '0 : div_cnt + DIV_W'(1);
      if (digit_end) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      end

      // A load on the boundary bypasses pending so it lands in the very next frame.
      if (boundary) begin
        if (bus.load) begin
          shadow_data <= bus.data_in;
          shadow_dp   <= bus.dp_in;
          upd_pending <= 1'b0;
        end else if (upd_pending) begin
          shadow_data <= pend_data;
          shadow_dp   <= pend_dp;
          upd_pending <= 1'b0;
        end
      end else if (bus.load) begin
        pend_data   <= bus.data_in;
        pend_dp     <= bus.dp_in;
        upd_pending <= 1'b1;
      end

      seg_q  <= seg_next ^ SEG_INV;
      dp_q   <= active_dp ^ DP_INV;
      an_q   <= an_onehot ^ AN_INV;
      tick_q <= (div_cnt == '0) && (idx == '0);
    end
  end

  assign bus.seg_out        = seg_q;
  assign bus.dp_out         = dp_q;
  assign bus.an_out         = an_q;
  assign bus.frame_tick     = tick_q;
  assign bus.update_pending = upd_pending;
endmodule

// File: tb/tb_display_mux_scan.sv
// tb/tb_display_mux_scan.sv - scoreboard bench for display_mux_scan (4 digits, divide-by-4, active-high)
module tb_display_mux_scan;
  typedef struct {
    int         t;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       tick;
    logic       pend;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t sb[$];

  logic [6:0] disp_seg[4];
  logic       disp_dp[4];
  logic       exp_pend;

  display_mux_scan_if #(.N_DIGITS(4)) bus();

  display_mux_scan #(
    .N_DIGITS(4),
    .REFRESH_DIV(4),
    .SEG_ACTIVE_LOW(0),
    .AN_ACTIVE_LOW(0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int t, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0d got %h expected %h", name, t, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("seg_out", e.t, {1'b0, bus.seg_out}, {1'b0, e.seg});
      chk("dp_out", e.t, {7'b0, bus.dp_out}, {7'b0, e.dp});
      chk("an_out", e.t, {4'b0, bus.an_out}, {4'b0, e.an});
      chk("frame_tick", e.t, {7'b0, bus.frame_tick}, {7'b0, e.tick});
      chk("update_pending", e.t, {7'b0, bus.update_pending}, {7'b0, e.pend});
    end
  end

  task automatic push_off(input int t);
    exp_t e;
    e.t = t; e.seg = 7'h00; e.dp = 1'b0; e.an = 4'b0000; e.tick = 1'b0; e.pend = 1'b0;
    sb.push_back(e);
  endtask

  task automatic push_scan(input int t);
    exp_t e;
    int   d;
    d = (t / 4) % 4;
    e.t = t; e.seg = disp_seg[d]; e.dp = disp_dp[d];
    e.an = 4'b0001 << d; e.tick = (t % 16 == 0); e.pend = exp_pend;
    sb.push_back(e);
  endtask

  task automatic set_frame(input logic [6:0] s0, input logic [6:0] s1,
                           input logic [6:0] s2, input logic [6:0] s3, input logic [3:0] dps);
    disp_seg[0] = s0; disp_seg[1] = s1; disp_seg[2] = s2; disp_seg[3] = s3;
    for (int i = 0; i < 4; i++) disp_dp[i] = dps[i];
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_pend = 1'b0;
    rst = 1'b1;
    bus.load = 1'b0;
    bus.data_in = 16'h0000;
    bus.dp_in = 4'b0000;
    bus.blank_lz_en = 1'b0;
    set_frame(7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'b0000);

    repeat (2) begin
      @(posedge clk);
      push_off(-1);
    end
    #1 rst = 1'b0;

    // One continuous run: frames 0..5, reset lands at t=90 (digit 2 of frame 5).
    for (int t = 0; t < 90; t++) begin
      bus.load = 1'b0;
      case (t)
        20: begin bus.load = 1'b1; bus.data_in = 16'h1A2F; bus.dp_in = 4'b0000; end
        36: begin bus.load = 1'b1; bus.data_in = 16'h0000; bus.blank_lz_en = 1'b1; end
        40: begin bus.load = 1'b1; bus.data_in = 16'h0042; end
        63: begin bus.load = 1'b1; bus.data_in = 16'h8888; end
        70: begin bus.load = 1'b1; bus.data_in = 16'h0005; bus.dp_in = 4'b0100; end
        84: begin bus.load = 1'b1; bus.data_in = 16'h3333; bus.dp_in = 4'b1111; end
        default: ;
      endcase
      if (t % 16 == 0) begin
        case (t / 16)
          2: set_frame(7'h71, 7'h5B, 7'h77, 7'h06, 4'b0000);
          3: set_frame(7'h5B, 7'h66, 7'h00, 7'h00, 4'b0000);
          4: set_frame(7'h7F, 7'h7F, 7'h7F, 7'h7F, 4'b0000);
          5: set_frame(7'h6D, 7'h00, 7'h00, 7'h00, 4'b0100);
          default: ;
        endcase
      end
      if (bus.load && (t % 16 != 15)) exp_pend = 1'b1;
      else if (t % 16 == 15) exp_pend = 1'b0;
      @(posedge clk);
      push_scan(t);
      #1;
    end

    rst = 1'b1;
    bus.load = 1'b1;
    bus.data_in = 16'h3333;
    bus.blank_lz_en = 1'b0;
    @(posedge clk);
    push_off(90);
    #1;
    rst = 1'b0;
    bus.load = 1'b0;
    exp_pend = 1'b0;
    set_frame(7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'b0000);

    for (int t = 0; t < 32; t++) begin
      @(posedge clk);
      push_scan(t);
      #1;
    end

    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d entries expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
